// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 4:1 mux scan sequencer and its mux4x1 bench.
package mux_scan_pkg;
  localparam int N_CH    = 4;
  localparam int SEL_W   = 2;
  localparam int DWELL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mux4x1.sv
// Combinational 4:1 multiplexer: s=n selects i[n].
// Zero latency; no flow control.
module mux4x1 (
  input  logic [3:0] i,
  input  logic [1:0] s,
  output logic       y
);
  assign y = i[s];
endmodule

// File: rtl/mux_dwell_counter.sv
// Per-channel dwell counter: hit marks the last cycle of a channel's dwell.
// Registered count; load wins over run, counter holds when run is low.
module mux_dwell_counter
  import mux_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell_in,
  output logic               hit
);
  logic [DWELL_W-1:0] dwell_reg;
  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_reg <= '0;
      cnt       <= '0;
    end else if (load) begin
      dwell_reg <= dwell_in;
      cnt       <= '0;
    end else if (run) begin
      // Clearing on hit keeps cnt <= dwell_reg, so the widest dwell never wraps.
      cnt <= hit ? '0 : cnt + 1'b1;
    end
  end

  assign hit = (cnt == dwell_reg);
endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a captured word through a 4:1 mux, one channel per dwell, reassembling y.
// done lands 4*(dwell+1) edges after start; start is ignored while busy.
module mux_scan_sequencer
  import mux_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [N_CH-1:0]    data_in,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y_in,
  output logic [N_CH-1:0]    i,
  output logic [SEL_W-1:0]   s,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic [N_CH-1:0]    word_out
);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_t            state_q, state_d;
  logic              accept, advance, run, hit;
  logic [N_CH-1:0]   i_q, word_q;
  logic [SEL_W-1:0]  s_q;

  mux_dwell_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .run      (run),
    .dwell_in (dwell),
    .hit      (hit)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SCAN;
        accept  = 1'b1;
      end
      // abort beats a coincident final sample: no sample, no done.
      SCAN: if (abort) begin
        state_d = IDLE;
      end else if (hit) begin
        advance = 1'b1;
        if (s_q == LAST_CH) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign run = (state_q == SCAN) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      s_q     <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        i_q    <= data_in;
        s_q    <= '0;
        word_q <= '0;
      end else if (advance) begin
        word_q[s_q] <= y_in;
        if (s_q != LAST_CH) s_q <= s_q + 1'b1;
      end
    end
  end

  assign i         = i_q;
  assign s         = s_q;
  assign word_out  = word_q;
  assign sel_valid = (state_q == SCAN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench: sequencer looped through mux4x1, random and directed scans.
module tb_mux_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] data_in = '0;
  logic [3:0] dwell = '0;
  logic       y;
  logic [3:0] i;
  logic [1:0] s;
  logic       sel_valid, busy, done;
  logic [3:0] word_out;

  mux_scan_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .data_in(data_in), .dwell(dwell), .y_in(y),
    .i(i), .s(s), .sel_valid(sel_valid), .busy(busy), .done(done),
    .word_out(word_out)
  );

  mux4x1 u_mux (.i(i), .s(s), .y(y));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected completions: reassembled word and the edge count at which done shows.
  logic [3:0] exp_word_q[$];
  int         exp_cyc_q[$];

  // Scan currently in flight, published by the driver for the monitor.
  bit         active = 1'b0;
  int         e0 = 0;
  int         cur_d = 0;
  logic [3:0] cur_data = '0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: per-cycle select/data pattern while scanning, scoreboard pop on done.
  always @(negedge clk) begin
    if (rst_n && active) begin
      int k;
      k = cyc - e0;
      if (k < 4 * (cur_d + 1)) begin
        check("sel_valid", int'(sel_valid), 1);
        check("s_step", int'(s), k / (cur_d + 1));
        check("i_held", int'(i), int'(cur_data));
        check("no_early_done", int'(done), 0);
      end
    end
    if (rst_n && done) begin
      if (exp_word_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [3:0] w;
        int         c;
        w = exp_word_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("word_out", int'(word_out), int'(w));
        check("done_cycle", cyc, c);
        check("busy_in_done", int'(busy), 1);
        check("sel_valid_in_done", int'(sel_valid), 0);
        check("s_in_done", int'(s), 3);
      end
      active = 1'b0;
    end
  end

  // One scan. abort_k > 0 raises abort for the edge E0+abort_k; restart pulses start while busy.
  task automatic scan(input logic [3:0] data, input int d, input int abort_k, input bit restart);
    @(negedge clk);
    start = 1'b1; data_in = data; dwell = 4'(d);
    @(posedge clk); #1;
    e0 = cyc; cur_data = data; cur_d = d; active = 1'b1;
    start = 1'b0; data_in = 4'($urandom); dwell = 4'($urandom);
    if (abort_k > 0) begin
      logic [3:0] partial;
      partial = '0;
      for (int n = 0; n < 4; n++)
        if ((n + 1) * (d + 1) < abort_k) partial[n] = data[n];
      repeat (abort_k - 1) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      if (restart) begin start = 1'b1; data_in = 4'hF; end
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0; active = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_no_done", int'(done), 0);
      check("abort_word", int'(word_out), int'(partial));
      repeat (2) @(negedge clk);
    end else begin
      int budget;
      exp_word_q.push_back(data);
      exp_cyc_q.push_back(e0 + 4 * (d + 1));
      budget = 4 * (d + 1) + 8;
      while (active && budget > 0) begin
        @(negedge clk); #1;
        budget--;
        if (active && restart && $urandom_range(0, 2) == 0) begin
          start = 1'b1; data_in = 4'hF;
        end else begin
          start = 1'b0;
        end
      end
      if (active) begin
        check("done_timeout", 0, 1);
        active = 1'b0;
        exp_word_q.delete(); exp_cyc_q.delete();
      end
      if (restart) begin
        // Now inside the DONE cycle: this start must be lost.
        start = 1'b1; data_in = 4'hF; dwell = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_done_lost", int'(busy), 0);
        check("i_after_scan", int'(i), int'(data));
        check("word_holds", int'(word_out), int'(data));
      end
      start = 1'b0;
    end
  endtask

  initial begin
    #1;
    check("rst_i", int'(i), 0);
    check("rst_s", int'(s), 0);
    check("rst_word", int'(word_out), 0);
    check("rst_flags", int'({sel_valid, busy, done}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    scan(4'b1010, 0, 0, 1'b0);
    scan(4'b0101, 2, 0, 1'b0);
    scan(4'b1100, 15, 0, 1'b0);
    scan(4'b0011, 1, 0, 1'b1);
    scan(4'b1111, 1, 5, 1'b0);
    scan(4'b1001, 2, 12, 1'b1);

    // Reset while s=2: outputs clear asynchronously, no done.
    @(negedge clk);
    start = 1'b1; data_in = 4'b1111; dwell = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_s", int'(s), 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_i", int'(i), 0);
    check("mid_rst_s", int'(s), 0);
    check("mid_rst_word", int'(word_out), 0);
    check("mid_rst_flags", int'({sel_valid, busy, done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    scan(4'b0110, 1, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      logic [3:0] dw;
      int d, ak;
      dw = 4'($urandom);
      d  = $urandom_range(0, 4);
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4 * (d + 1)) : 0;
      scan(dw, d, ak, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_word_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
